// File: rtl/fifo_async_lvl.sv
// Dual-clock FIFO: Gray-coded pointer crossing, fill levels on both sides,
// programmable almost-full/almost-empty, sticky error flags, optional FWFT port.
module fifo_async_lvl #(
  parameter int WIDTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AFULL_TH  = (1 << ADDR_W) - 2,
  parameter int AEMPTY_TH = 1,
  parameter bit FWFT      = 1'b0
) (
  input  logic              clk_a,
  input  logic              rst_n_a,
  input  logic              clk_b,
  input  logic              rst_n_b,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow,
  input  logic              ovf_clr,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_level,
  output logic              underflow,
  input  logic              unf_clr
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;
  localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_TH);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_TH);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_gray;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_gray_sync_p0;
  logic [PW-1:0] rd_gray_sync_p1;
  logic          wr_accept;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_gray;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] wr_gray_sync_p0;
  logic [PW-1:0] wr_gray_sync_p1;
  logic [PW-1:0] wr_bin_sync;
  logic          empty_core;
  logic          rd_advance;

  // ---------------- write domain (clk_a) ----------------
  assign wr_accept  = wr_en & ~full;
  assign wr_ptr_nxt = wr_ptr + PTR_ONE;

  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) begin
      wr_ptr  <= '0;
      wr_gray <= '0;
    end else if (wr_accept) begin
      wr_ptr  <= wr_ptr_nxt;
      wr_gray <= bin2gray(wr_ptr_nxt);
    end
  end

  always_ff @(posedge clk_a) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // read pointer crossing into clk_a: two-flop synchroniser
  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) begin
      rd_gray_sync_p0 <= '0;
      rd_gray_sync_p1 <= '0;
    end else begin
      rd_gray_sync_p0 <= rd_gray;
      rd_gray_sync_p1 <= rd_gray_sync_p0;
    end
  end

  // A dropped write sets the flag even when a clear arrives in the same cycle.
  always_ff @(posedge clk_a or negedge rst_n_a) begin
    if (!rst_n_a) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign full        = (wr_gray == {~rd_gray_sync_p1[PW-1:PW-2], rd_gray_sync_p1[PW-3:0]});
  assign wr_level    = wr_ptr - gray2bin(rd_gray_sync_p1);
  assign almost_full = (wr_level >= AFULL_LVL);

  // ---------------- read domain (clk_b) ----------------
  assign rd_ptr_nxt = rd_ptr + PTR_ONE;

  always_ff @(posedge clk_b or negedge rst_n_b) begin
    if (!rst_n_b) begin
      rd_ptr  <= '0;
      rd_gray <= '0;
    end else if (rd_advance) begin
      rd_ptr  <= rd_ptr_nxt;
      rd_gray <= bin2gray(rd_ptr_nxt);
    end
  end

  // write pointer crossing into clk_b: two-flop synchroniser
  always_ff @(posedge clk_b or negedge rst_n_b) begin
    if (!rst_n_b) begin
      wr_gray_sync_p0 <= '0;
      wr_gray_sync_p1 <= '0;
    end else begin
      wr_gray_sync_p0 <= wr_gray;
      wr_gray_sync_p1 <= wr_gray_sync_p0;
    end
  end

  assign wr_bin_sync = gray2bin(wr_gray_sync_p1);
  assign empty_core  = (wr_gray_sync_p1 == rd_gray);

  always_ff @(posedge clk_b or negedge rst_n_b) begin
    if (!rst_n_b) begin
      underflow <= 1'b0;
    end else if (rd_en && empty) begin
      underflow <= 1'b1;
    end else if (unf_clr) begin
      underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      logic out_vld;
      logic pop;
      logic load;

      // The output register refills on the same edge it is popped.
      assign pop  = rd_en & out_vld;
      assign load = ~empty_core & (~out_vld | pop);

      always_ff @(posedge clk_b or negedge rst_n_b) begin
        if (!rst_n_b) begin
          out_vld <= 1'b0;
          rd_data <= '0;
        end else if (load) begin
          out_vld <= 1'b1;
          rd_data <= mem[rd_ptr[ADDR_W-1:0]];
        end else if (pop) begin
          out_vld <= 1'b0;
        end
      end

      assign rd_advance = load;
      assign empty      = ~out_vld;
      assign rd_valid   = out_vld;
      assign rd_level   = (wr_bin_sync - rd_ptr) + {{ADDR_W{1'b0}}, out_vld};
    end else begin : g_std
      logic vld_p0;

      assign rd_advance = rd_en & ~empty_core;

      always_ff @(posedge clk_b or negedge rst_n_b) begin
        if (!rst_n_b) begin
          vld_p0  <= 1'b0;
          rd_data <= '0;
        end else begin
          vld_p0 <= rd_advance;
          if (rd_advance) begin
            rd_data <= mem[rd_ptr[ADDR_W-1:0]];
          end
        end
      end

      assign empty    = empty_core;
      assign rd_valid = vld_p0;
      assign rd_level = wr_bin_sync - rd_ptr;
    end
  endgenerate

  assign almost_empty = (rd_level <= AEMPTY_LVL);

endmodule

// File: tb/tb_fifo_async_lvl.sv
// Directed bench for fifo_async_lvl: one standard-mode and one FWFT instance,
// clocks in a 10:13 ratio with edges that never coincide.
module tb_fifo_async_lvl;
  logic clk_a = 1'b0;
  logic clk_b = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;

  always #10 clk_a = ~clk_a;
  always #13 clk_b = ~clk_b;

  logic       s_wr_en = 1'b0, s_ovf_clr = 1'b0, s_rd_en = 1'b0, s_unf_clr = 1'b0;
  logic [7:0] s_wr_data = 8'h00;
  logic       s_full, s_afull, s_ovf, s_rd_valid, s_empty, s_aempty, s_unf;
  logic [3:0] s_wr_level, s_rd_level;
  logic [7:0] s_rd_data;

  logic       f_wr_en = 1'b0, f_ovf_clr = 1'b0, f_rd_en = 1'b0, f_unf_clr = 1'b0;
  logic [7:0] f_wr_data = 8'h00;
  logic       f_full, f_afull, f_ovf, f_rd_valid, f_empty, f_aempty, f_unf;
  logic [3:0] f_wr_level, f_rd_level;
  logic [7:0] f_rd_data;

  fifo_async_lvl #(.WIDTH(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1'b0)) u_std (
    .clk_a(clk_a), .rst_n_a(rst_n_a), .clk_b(clk_b), .rst_n_b(rst_n_b),
    .wr_en(s_wr_en), .wr_data(s_wr_data), .full(s_full), .almost_full(s_afull),
    .wr_level(s_wr_level), .overflow(s_ovf), .ovf_clr(s_ovf_clr),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty),
    .almost_empty(s_aempty), .rd_level(s_rd_level), .underflow(s_unf), .unf_clr(s_unf_clr)
  );

  fifo_async_lvl #(.WIDTH(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1), .FWFT(1'b1)) u_fw (
    .clk_a(clk_a), .rst_n_a(rst_n_a), .clk_b(clk_b), .rst_n_b(rst_n_b),
    .wr_en(f_wr_en), .wr_data(f_wr_data), .full(f_full), .almost_full(f_afull),
    .wr_level(f_wr_level), .overflow(f_ovf), .ovf_clr(f_ovf_clr),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
    .almost_empty(f_aempty), .rd_level(f_rd_level), .underflow(f_unf), .unf_clr(f_unf_clr)
  );

  typedef struct {
    logic       wr_en;
    logic [7:0] data;
    logic       ovf_clr;
    logic       e_full;
    logic       e_af;
    logic [3:0] e_lvl;
    logic       e_ovf;
  } wvec_t;

  typedef struct {
    logic       rd_en;
    logic       unf_clr;
    logic       e_vld;
    logic [7:0] e_data;
    logic       e_empty;
    logic [3:0] e_lvl;
    logic       e_ae;
    logic       e_unf;
  } rvec_t;

  wvec_t wv[11];
  rvec_t rv[11];

  int checks = 0;
  int failures = 0;
  int wn, wguard, rn, rgot, rguard, nwait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_a();
    @(posedge clk_a);
    #1;
  endtask

  task automatic tick_b();
    @(posedge clk_b);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".s_full"},     32'(s_full), 0);
    chk({tag, ".s_afull"},    32'(s_afull), 0);
    chk({tag, ".s_wr_level"}, 32'(s_wr_level), 0);
    chk({tag, ".s_ovf"},      32'(s_ovf), 0);
    chk({tag, ".s_empty"},    32'(s_empty), 1);
    chk({tag, ".s_aempty"},   32'(s_aempty), 1);
    chk({tag, ".s_rd_level"}, 32'(s_rd_level), 0);
    chk({tag, ".s_rd_valid"}, 32'(s_rd_valid), 0);
    chk({tag, ".s_rd_data"},  32'(s_rd_data), 0);
    chk({tag, ".s_unf"},      32'(s_unf), 0);
    chk({tag, ".f_full"},     32'(f_full), 0);
    chk({tag, ".f_afull"},    32'(f_afull), 0);
    chk({tag, ".f_wr_level"}, 32'(f_wr_level), 0);
    chk({tag, ".f_ovf"},      32'(f_ovf), 0);
    chk({tag, ".f_empty"},    32'(f_empty), 1);
    chk({tag, ".f_aempty"},   32'(f_aempty), 1);
    chk({tag, ".f_rd_level"}, 32'(f_rd_level), 0);
    chk({tag, ".f_rd_valid"}, 32'(f_rd_valid), 0);
    chk({tag, ".f_rd_data"},  32'(f_rd_data), 0);
    chk({tag, ".f_unf"},      32'(f_unf), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // fill to full, overflow, then set-over-clear on the sticky flag
    wv[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    wv[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0};
    wv[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0};
    wv[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0};
    wv[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0};
    wv[5]  = '{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 4'd6, 1'b0};
    wv[6]  = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0};
    wv[7]  = '{1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 4'd8, 1'b0};
    wv[8]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 4'd8, 1'b1};
    wv[9]  = '{1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 4'd8, 1'b1};
    wv[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'd8, 1'b0};

    // drain in order, then underflow with set-over-clear
    rv[0]  = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 4'd7, 1'b0, 1'b0};
    rv[1]  = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 4'd6, 1'b0, 1'b0};
    rv[2]  = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 4'd5, 1'b0, 1'b0};
    rv[3]  = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 4'd4, 1'b0, 1'b0};
    rv[4]  = '{1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 4'd3, 1'b0, 1'b0};
    rv[5]  = '{1'b1, 1'b0, 1'b1, 8'h06, 1'b0, 4'd2, 1'b0, 1'b0};
    rv[6]  = '{1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 4'd1, 1'b1, 1'b0};
    rv[7]  = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 4'd0, 1'b1, 1'b0};
    rv[8]  = '{1'b1, 1'b0, 1'b0, 8'h08, 1'b1, 4'd0, 1'b1, 1'b1};
    rv[9]  = '{1'b1, 1'b1, 1'b0, 8'h08, 1'b1, 4'd0, 1'b1, 1'b1};
    rv[10] = '{1'b0, 1'b1, 1'b0, 8'h08, 1'b1, 4'd0, 1'b1, 1'b0};

    tick_a();
    tick_a();
    chk_reset("init");
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    tick_a();

    for (int i = 0; i < 11; i++) begin
      s_wr_en   = wv[i].wr_en;
      s_wr_data = wv[i].data;
      s_ovf_clr = wv[i].ovf_clr;
      tick_a();
      chk($sformatf("fill[%0d].full", i),     32'(s_full),     32'(wv[i].e_full));
      chk($sformatf("fill[%0d].afull", i),    32'(s_afull),    32'(wv[i].e_af));
      chk($sformatf("fill[%0d].wr_level", i), 32'(s_wr_level), 32'(wv[i].e_lvl));
      chk($sformatf("fill[%0d].overflow", i), 32'(s_ovf),      32'(wv[i].e_ovf));
    end
    s_wr_en = 1'b0;
    s_ovf_clr = 1'b0;

    for (int i = 0; i < 4; i++) tick_b();
    chk("pre_read.rd_level", 32'(s_rd_level), 8);
    chk("pre_read.empty",    32'(s_empty), 0);
    chk("pre_read.aempty",   32'(s_aempty), 0);

    for (int i = 0; i < 11; i++) begin
      s_rd_en   = rv[i].rd_en;
      s_unf_clr = rv[i].unf_clr;
      tick_b();
      chk($sformatf("read[%0d].rd_valid", i), 32'(s_rd_valid), 32'(rv[i].e_vld));
      chk($sformatf("read[%0d].rd_data", i),  32'(s_rd_data),  32'(rv[i].e_data));
      chk($sformatf("read[%0d].empty", i),    32'(s_empty),    32'(rv[i].e_empty));
      chk($sformatf("read[%0d].rd_level", i), 32'(s_rd_level), 32'(rv[i].e_lvl));
      chk($sformatf("read[%0d].aempty", i),   32'(s_aempty),   32'(rv[i].e_ae));
      chk($sformatf("read[%0d].underflow", i), 32'(s_unf),     32'(rv[i].e_unf));
    end
    s_rd_en = 1'b0;
    s_unf_clr = 1'b0;

    nwait = 0;
    tick_a();
    while (s_full && nwait < 6) begin
      tick_a();
      nwait++;
    end
    chk("drain.full",     32'(s_full), 0);
    chk("drain.wr_level", 32'(s_wr_level), 0);
    chk("drain.afull",    32'(s_afull), 0);

    // almost_full rises on the 6th write, falls once one read has crossed over
    for (int i = 0; i < 6; i++) begin
      s_wr_en = 1'b1;
      s_wr_data = 8'(8'h11 + i);
      tick_a();
      if (i == 4) chk("thr.afull_5", 32'(s_afull), 0);
      if (i == 5) chk("thr.afull_6", 32'(s_afull), 1);
    end
    s_wr_en = 1'b0;
    for (int i = 0; i < 4; i++) tick_b();
    s_rd_en = 1'b1;
    tick_b();
    s_rd_en = 1'b0;
    chk("thr.rd_data", 32'(s_rd_data), 32'h11);
    nwait = 0;
    tick_a();
    while (s_afull && nwait < 8) begin
      tick_a();
      nwait++;
    end
    chk("thr.afull_fall", 32'(s_afull), 0);
    chk("thr.wr_level",   32'(s_wr_level), 5);
    for (int k = 0; k < 5; k++) begin
      s_rd_en = 1'b1;
      tick_b();
      chk($sformatf("thr.drain[%0d]", k), 32'(s_rd_data), 32'(8'h12 + k));
    end
    s_rd_en = 1'b0;

    // wrap-around: concurrent writer and reader across the pointer wrap
    fork
      begin
        wn = 0;
        wguard = 0;
        tick_a();
        while (wn < 20 && wguard < 500) begin
          if (!s_full) begin
            s_wr_en = 1'b1;
            s_wr_data = 8'(8'h40 + wn);
            wn++;
          end else begin
            s_wr_en = 1'b0;
          end
          tick_a();
          wguard++;
        end
        s_wr_en = 1'b0;
      end
      begin
        rn = 0;
        rgot = 0;
        rguard = 0;
        tick_b();
        while (rgot < 20 && rguard < 500) begin
          if (s_rd_valid) begin
            chk($sformatf("wrap.data[%0d]", rgot), 32'(s_rd_data), 32'(8'h40 + rgot));
            rgot++;
          end
          if (!s_empty && rn < 20) begin
            s_rd_en = 1'b1;
            rn++;
          end else begin
            s_rd_en = 1'b0;
          end
          tick_b();
          rguard++;
        end
        s_rd_en = 1'b0;
      end
    join
    chk("wrap.count", 32'(rgot), 20);
    for (int i = 0; i < 6; i++) tick_a();
    for (int i = 0; i < 6; i++) tick_b();
    chk("wrap.empty",     32'(s_empty), 1);
    chk("wrap.rd_level",  32'(s_rd_level), 0);
    chk("wrap.wr_level",  32'(s_wr_level), 0);
    chk("wrap.underflow", 32'(s_unf), 0);
    chk("wrap.overflow",  32'(s_ovf), 0);

    // FWFT: head word appears without rd_en
    tick_a();
    f_wr_en = 1'b1;
    f_wr_data = 8'hA5;
    tick_a();
    f_wr_en = 1'b0;
    nwait = 0;
    while (f_empty && nwait < 8) begin
      tick_b();
      nwait++;
    end
    chk("fwft.edges_within_4", 32'(nwait <= 4), 1);
    chk("fwft.empty",    32'(f_empty), 0);
    chk("fwft.rd_data",  32'(f_rd_data), 32'hA5);
    chk("fwft.rd_valid", 32'(f_rd_valid), 1);
    chk("fwft.rd_level", 32'(f_rd_level), 1);
    tick_b();
    tick_b();
    chk("fwft.hold_data",  32'(f_rd_data), 32'hA5);
    chk("fwft.hold_level", 32'(f_rd_level), 1);
    f_rd_en = 1'b1;
    tick_b();
    f_rd_en = 1'b0;
    chk("fwft.pop_empty",    32'(f_empty), 1);
    chk("fwft.pop_level",    32'(f_rd_level), 0);
    chk("fwft.pop_valid",    32'(f_rd_valid), 0);
    chk("fwft.pop_underflow", 32'(f_unf), 0);
    f_rd_en = 1'b1;
    tick_b();
    f_rd_en = 1'b0;
    chk("fwft.unf_set",   32'(f_unf), 1);
    chk("fwft.unf_level", 32'(f_rd_level), 0);
    f_unf_clr = 1'b1;
    tick_b();
    f_unf_clr = 1'b0;
    chk("fwft.unf_clr", 32'(f_unf), 0);

    // FWFT back-to-back pops with same-edge refill
    tick_a();
    for (int i = 0; i < 3; i++) begin
      f_wr_en = 1'b1;
      f_wr_data = 8'(8'hB1 + i);
      tick_a();
    end
    f_wr_en = 1'b0;
    for (int i = 0; i < 5; i++) tick_b();
    chk("b2b.rd_level", 32'(f_rd_level), 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b.head[%0d]", k),  32'(f_rd_data), 32'(8'hB1 + k));
      chk($sformatf("b2b.empty[%0d]", k), 32'(f_empty), 0);
      f_rd_en = 1'b1;
      tick_b();
    end
    f_rd_en = 1'b0;
    chk("b2b.end_empty", 32'(f_empty), 1);
    chk("b2b.end_level", 32'(f_rd_level), 0);

    // reset with data stored and a sticky flag set
    tick_a();
    for (int i = 0; i < 5; i++) begin
      s_wr_en = 1'b1;
      s_wr_data = 8'(8'h51 + i);
      tick_a();
    end
    s_wr_en = 1'b0;
    f_rd_en = 1'b1;
    tick_b();
    f_rd_en = 1'b0;
    for (int i = 0; i < 4; i++) tick_b();
    chk("mid.pre_rd_level", 32'(s_rd_level), 5);
    chk("mid.pre_f_unf",    32'(f_unf), 1);
    #3;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    #1;
    chk_reset("mid");
    tick_a();
    tick_a();
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    tick_a();
    s_wr_en = 1'b1;
    s_wr_data = 8'h3C;
    f_wr_en = 1'b1;
    f_wr_data = 8'h3C;
    tick_a();
    s_wr_en = 1'b0;
    f_wr_en = 1'b0;
    chk("post.s_wr_level", 32'(s_wr_level), 1);
    for (int i = 0; i < 5; i++) tick_b();
    chk("post.s_rd_level", 32'(s_rd_level), 1);
    chk("post.f_rd_data",  32'(f_rd_data), 32'h3C);
    chk("post.f_empty",    32'(f_empty), 0);
    s_rd_en = 1'b1;
    tick_b();
    s_rd_en = 1'b0;
    chk("post.s_rd_valid", 32'(s_rd_valid), 1);
    chk("post.s_rd_data",  32'(s_rd_data), 32'h3C);
    chk("post.s_empty",    32'(s_empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
